mau_queued: RTL and testbench

// - Parametrised memory access unit: queues load requests, gathers byte beats from memory, assembles 1- or BEATS-beat

---
 rtl/mau_if.sv | 30 +++
 rtl/mau_queued.sv | 98 +++++++++
 tb/tb_mau_queued.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mau_if.sv
// mau_if: request, memory-beat and writeback signals of the memory access unit.
interface mau_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int DST_W  = 4,
    parameter int DEPTH  = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [DST_W-1:0]           req_dst;
    logic                       req_wide;
    logic                       req_signed;
    logic [DATA_W-1:0]          data_in;
    logic                       mem_res;
    logic                       mem_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_W-1:0]           out;
    logic [DST_W-1:0]           o_dst;
    logic [$clog2(DEPTH+1)-1:0] pending_cnt;
    logic                       err_unexpected;
    modport slave (
        input  req_valid, req_dst, req_wide, req_signed, data_in, mem_res, out_ready,
        output req_ready, mem_ready, out_valid, out, o_dst, pending_cnt, err_unexpected
    );
    modport master (
        output req_valid, req_dst, req_wide, req_signed, data_in, mem_res, out_ready,
        input  req_ready, mem_ready, out_valid, out, o_dst, pending_cnt, err_unexpected
    );
endinterface

// File: rtl/mau_queued.sv
// mau_queued: in-order load queue, beat assembly and writeback.
// Define MAU_SIGN_EXT_EN to sign-extend narrow loads flagged req_signed.
module mau_queued #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int DST_W  = 4,
    parameter int DEPTH  = 4
) (
    input logic  cpu_clk,
    input logic  cpu_rst,
    mau_if.slave m
);
    localparam int BEATS = OUT_W / DATA_W;
    localparam int BW    = $clog2(BEATS);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [0:0] S_WAIT = 1'b0;
    localparam logic [0:0] S_ASM  = 1'b1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    logic [DST_W-1:0]        q_dst [DEPTH];
    logic [DEPTH-1:0]        q_wide;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [0:0]              state;
    logic [BW-1:0]           bcnt;
    logic [OUT_W-DATA_W-1:0] lanes;
    logic                    h_wide, h_sgn, is_final, push, beat, done;
    logic [OUT_W-1:0]        res;

    assign push     = m.req_valid && m.req_ready;
    assign h_wide   = q_wide[rd_ptr];
    assign is_final = !h_wide || (state == S_ASM && bcnt == LAST);
    // Only the completing beat needs a free writeback slot; earlier beats keep flowing.
    assign m.mem_ready   = cpu_rst && cnt != '0 && (!m.out_valid || m.out_ready || !is_final);
    assign beat          = m.mem_res && m.mem_ready;
    assign done          = beat && is_final;
    assign cnt_nxt       = cnt + CW'(push) - CW'(done);
    assign m.pending_cnt = cnt;

`ifdef MAU_SIGN_EXT_EN
    logic [DEPTH-1:0] q_sgn;
    assign h_sgn = q_sgn[rd_ptr];
    always_ff @(posedge cpu_clk)
        if (push) q_sgn[wr_ptr] <= m.req_signed;
`else
    logic unused_sgn;
    assign unused_sgn = m.req_signed;
    assign h_sgn      = 1'b0;
`endif

    // The final lane comes straight from the bus; earlier lanes were captured in order.
    assign res = h_wide ? {m.data_in, lanes}
                        : {{(OUT_W-DATA_W){h_sgn && m.data_in[DATA_W-1]}}, m.data_in};

    always_ff @(posedge cpu_clk)
        if (push) begin
            q_dst[wr_ptr]  <= m.req_dst;
            q_wide[wr_ptr] <= m.req_wide;
        end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            cnt              <= '0;
            m.req_ready      <= 1'b0;
            state            <= S_WAIT;
            bcnt             <= '0;
            lanes            <= '0;
            m.out_valid      <= 1'b0;
            m.out            <= '0;
            m.o_dst          <= '0;
            m.err_unexpected <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr + PW'(done);
            cnt         <= cnt_nxt;
            m.req_ready <= cnt_nxt != CW'(DEPTH);
            if (m.mem_res && !m.mem_ready) m.err_unexpected <= 1'b1;
            if (beat && !done) begin
                for (int i = 0; i < BEATS - 1; i++)
                    if (bcnt == BW'(i)) lanes[i*DATA_W +: DATA_W] <= m.data_in;
                bcnt  <= bcnt + BW'(1);
                state <= S_ASM;
            end
            if (done) begin
                bcnt        <= '0;
                state       <= S_WAIT;
                m.out       <= res;
                m.o_dst     <= q_dst[rd_ptr];
                m.out_valid <= 1'b1;
            end else if (m.out_ready) begin
                m.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mau_queued.sv
// tb_mau_queued: directed and random load traffic checked against a queue-based reference model.
module tb_mau_queued;
    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;
    localparam int DST_W  = 4;
    localparam int DEPTH  = 4;
    localparam int BEATS  = OUT_W / DATA_W;
`ifdef MAU_SIGN_EXT_EN
    localparam bit SX = 1'b1;
`else
    localparam bit SX = 1'b0;
`endif

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b0;
    int errors = 0;
    int checks = 0;

    mau_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DST_W(DST_W), .DEPTH(DEPTH)) bus ();
    mau_queued #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DST_W(DST_W), .DEPTH(DEPTH)) dut (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .m(bus.slave)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [3:0] dst;
        bit         wide;
        bit         sgn;
    } req_t;

    req_t       rq[$];
    int         nb = 0;
    logic [15:0] acc = '0;
    bit         mv = 0, mrr = 0, merr = 0, armed = 0;
    logic [15:0] mout = '0;
    logic [3:0] mdst = '0;
    logic [3:0] wb[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs to the model, advance the model.
    task automatic cyc(bit rv, logic [3:0] dst, bit wide, bit sgn, bit mres, logic [7:0] din, bit ordy);
        bit last, mr, push, beat;
        req_t r;
        bus.req_valid  = rv;
        bus.req_dst    = dst;
        bus.req_wide   = wide;
        bus.req_signed = sgn;
        bus.mem_res    = mres;
        bus.data_in    = din;
        bus.out_ready  = ordy;
        #1;
        last = rq.size() > 0 && (!rq[0].wide || nb == BEATS - 1);
        mr   = cpu_rst && rq.size() > 0 && (!mv || ordy || !last);
        if (armed) begin
            chk("req_ready", 32'(bus.req_ready), 32'(mrr));
            chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
            chk("out_valid", 32'(bus.out_valid), 32'(mv));
            chk("out", 32'(bus.out), 32'(mout));
            chk("o_dst", 32'(bus.o_dst), 32'(mdst));
            chk("pending_cnt", 32'(bus.pending_cnt), rq.size());
            chk("err_unexpected", 32'(bus.err_unexpected), 32'(merr));
        end
        if (cpu_rst && bus.out_valid && ordy) wb.push_back(bus.o_dst);
        push = rv && mrr;
        beat = mres && mr;
        if (!cpu_rst) begin
            rq.delete();
            nb = 0; acc = '0; mv = 0; mrr = 0; merr = 0; mout = '0; mdst = '0;
        end else begin
            if (mres && !mr) merr = 1;
            if (ordy) mv = 0;
            if (beat) begin
                if (rq[0].wide) begin
                    acc = acc | (16'(din) << (8 * nb));
                    nb++;
                end
                if (!rq[0].wide || nb == BEATS) begin
                    mout = rq[0].wide ? acc : ((SX && rq[0].sgn && din[7]) ? {8'hFF, din} : {8'h00, din});
                    mdst = rq[0].dst;
                    mv   = 1;
                    void'(rq.pop_front());
                    nb  = 0;
                    acc = '0;
                end
            end
            if (push) begin
                r.dst = dst; r.wide = wide; r.sgn = sgn;
                rq.push_back(r);
            end
            mrr = rq.size() != DEPTH;
        end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic push_req(logic [3:0] dst, bit wide, bit sgn);
        cyc(1, dst, wide, sgn, 0, 8'h00, 1);
    endtask

    task automatic give_beat(logic [7:0] din, bit ordy);
        cyc(0, 4'h0, 0, 0, 1, din, ordy);
    endtask

    task automatic idle(bit ordy);
        cyc(0, 4'h0, 0, 0, 0, 8'h00, ordy);
    endtask

    initial begin
        @(negedge cpu_clk);
        idle(1);
        armed = 1;
        idle(1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        cpu_rst = 1'b1;
        idle(1);
        idle(1);

        // narrow unsigned
        push_req(4'd3, 0, 0);
        chk("narrow_pending", 32'(bus.pending_cnt), 32'd1);
        give_beat(8'h85, 1);
        chk("narrow_out", 32'(bus.out), 32'h0085);
        chk("narrow_dst", 32'(bus.o_dst), 32'd3);
        idle(1);
        chk("narrow_one_cycle", 32'(bus.out_valid), 32'd0);

        // narrow signed
        push_req(4'd5, 0, 1);
        give_beat(8'h85, 1);
        chk("signed_85", 32'(bus.out), SX ? 32'hFF85 : 32'h0085);
        push_req(4'd5, 0, 1);
        give_beat(8'h7F, 1);
        chk("signed_7f", 32'(bus.out), 32'h007F);
        idle(1);

        // wide little-endian
        push_req(4'd7, 1, 0);
        give_beat(8'h34, 1);
        chk("wide_no_early_valid", 32'(bus.out_valid), 32'd0);
        give_beat(8'h12, 1);
        chk("wide_out", 32'(bus.out), 32'h1234);
        chk("wide_dst", 32'(bus.o_dst), 32'd7);
        idle(1);

        // fill the queue, fifth request is held off
        wb.delete();
        for (int i = 1; i <= 4; i++) push_req(4'(i), 0, 0);
        chk("full_pending", 32'(bus.pending_cnt), 32'd4);
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        push_req(4'd9, 0, 0);
        chk("full_held_off", 32'(bus.pending_cnt), 32'd4);
        for (int i = 0; i < 4; i++) give_beat(8'hA0 + 8'(i), 1);
        idle(1);
        chk("order_count", wb.size(), 32'd4);
        for (int i = 0; i < 4 && i < wb.size(); i++) chk("order_dst", 32'(wb[i]), 32'(i + 1));

        // writeback stall with a wide head behind it
        push_req(4'd8, 0, 0);
        push_req(4'd9, 1, 0);
        give_beat(8'h11, 0);
        give_beat(8'h22, 0);
        chk("stall_pending", 32'(bus.pending_cnt), 32'd1);
        idle(0);
        chk("stall_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("stall_out_stable", 32'(bus.out), 32'h0011);
        give_beat(8'h33, 1);
        chk("stall_out", 32'(bus.out), 32'h3322);
        chk("stall_dst", 32'(bus.o_dst), 32'd9);
        idle(1);

        // reset mid-transfer, then a beat with nothing queued
        push_req(4'd10, 1, 0);
        give_beat(8'h44, 1);
        cpu_rst = 1'b0;
        idle(1);
        cpu_rst = 1'b1;
        idle(1);
        chk("midrst_pending", 32'(bus.pending_cnt), 32'd0);
        chk("midrst_out", 32'(bus.out), 32'd0);
        give_beat(8'h55, 1);
        chk("err_set", 32'(bus.err_unexpected), 32'd1);
        idle(1);
        idle(1);
        chk("err_sticky", 32'(bus.err_unexpected), 32'd1);

        // random traffic with occasional resets
        cpu_rst = 1'b0;
        idle(1);
        cpu_rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cpu_rst = ($urandom % 150) != 0;
            cyc(1'($urandom % 2), 4'($urandom), 1'($urandom % 2), 1'($urandom % 2),
                ($urandom % 10) < 6, 8'($urandom), ($urandom % 10) < 7);
        end
        cpu_rst = 1'b1;
        for (int i = 0; i < 20; i++) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
